// File: rtl/scm_write_ctrl.sv
// Write-request front end for the standard-cell memory array: one-deep request buffer,
// setup/strobe/hold sequencing, and one-hot word enable into the DGW clock-gating stage.
module scm_write_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_WIDTH-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       scan_en,
  output logic [(2**ADDR_WIDTH)-1:0] E,
  output logic                       SE,
  output logic [DATA_WIDTH-1:0]      WData,
  output logic                       busy
);

  localparam int NWORDS = 2**ADDR_WIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_act_addr;
  logic [DATA_WIDTH-1:0] r_act_data;
  logic                  r_pend_valid;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [DATA_WIDTH-1:0] r_pend_data;
  logic [NWORDS-1:0]     r_e;

  logic                  w_accept;
  logic [NWORDS-1:0]     w_onehot;

  assign wr_ready = !r_pend_valid && !scan_en;
  assign w_accept = wr_valid && wr_ready;
  assign w_onehot = {{(NWORDS-1){1'b0}}, 1'b1} << r_act_addr;

  // Scan forces E low combinationally; r_e itself is frozen so a STROBE is re-presented on release.
  assign E     = scan_en ? '0 : r_e;
  assign SE    = scan_en;
  assign WData = r_act_data;
  assign busy  = (r_state != S_IDLE) || r_pend_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_act_addr   <= '0;
      r_act_data   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_e          <= '0;
    end else if (!scan_en) begin
      case (r_state)
        S_IDLE: begin
          r_e <= '0;
          if (w_accept) begin
            r_act_addr <= wr_addr;
            r_act_data <= wr_data;
            r_state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_e     <= w_onehot;
          r_state <= S_STROBE;
          if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= wr_addr;
            r_pend_data  <= wr_data;
          end
        end
        S_STROBE: begin
          r_e     <= '0;
          r_state <= S_HOLD;
          if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= wr_addr;
            r_pend_data  <= wr_data;
          end
        end
        S_HOLD: begin
          r_e <= '0;
          // wr_ready is low whenever the slot is full, so the two load paths are exclusive.
          if (r_pend_valid) begin
            r_act_addr   <= r_pend_addr;
            r_act_data   <= r_pend_data;
            r_pend_valid <= 1'b0;
            r_state      <= S_SETUP;
          end else if (w_accept) begin
            r_act_addr <= wr_addr;
            r_act_data <= wr_data;
            r_state    <= S_SETUP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_e     <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scm_write_ctrl.sv
// Scoreboard bench for scm_write_ctrl: every accepted write must produce exactly one E pulse,
// at cycle max(accept+1, previous_pulse+3), carrying its address and data.
module tb_scm_write_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       scan_en = 1'b0;
  logic [7:0] E;
  logic       SE;
  logic [7:0] WData;
  logic       busy;

  scm_write_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .scan_en(scan_en),
    .E(E), .SE(SE), .WData(WData), .busy(busy)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   last_pulse = -100;
  logic prev_e = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request and hold it until accepted; returns the accepting edge count.
  task automatic send(input logic [2:0] a, input logic [7:0] d, output int k);
    logic acc;
    int   pulse;
    exp_t item;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    k = -1;
    for (int n = 0; n < 50; n++) begin
      acc = wr_ready && rst_n;
      @(posedge clk);
      #1;
      if (acc) begin
        k = cyc;
        break;
      end
    end
    wr_valid = 1'b0;
    if (k < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept of addr %0d", a);
    end else begin
      pulse = (k + 1 > last_pulse + 3) ? k + 1 : last_pulse + 3;
      last_pulse = pulse;
      item.addr = a;
      item.data = d;
      item.cyc  = pulse;
      sb.push_back(item);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < n && guard < 1000);
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || sb.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_reached", busy, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every E pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_e = 1'b0;
    end else begin
      chk("e_onehot", ($countones(E) <= 1), 1);
      if (E != 0) begin
        chk("e_not_consecutive", prev_e, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_E: got E=%0h expected no pulse", E);
        end else begin
          exp_t it;
          logic [7:0] oh;
          it = sb.pop_front();
          oh = 8'b1 << it.addr;
          chk("sb_E", E, oh);
          chk("sb_WData", WData, it.data);
          chk("sb_cycle", cyc, it.cyc);
        end
      end
      prev_e = (E != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, gap;
    logic [7:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_E", E, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_WData", WData, 0);
    chk("rst_SE", SE, 0);
    chk("rst_busy_rel", busy, 0);

    // Single write
    send(3'd0, 8'hA5, k);
    wait_cyc(k);
    chk("t1_wdata_setup", WData, 8'hA5);
    chk("t1_E_setup", E, 0);
    wait_cyc(k + 1);
    chk("t1_E_strobe", E, 8'h01);
    wait_cyc(k + 2);
    chk("t1_E_hold", E, 0);
    chk("t1_wdata_hold", WData, 8'hA5);
    chk("t1_busy_hold", busy, 1);
    wait_cyc(k + 3);
    chk("t1_busy_done", busy, 0);
    chk("t1_wdata_kept", WData, 8'hA5);
    wait_idle();

    // Back-to-back into the pending slot
    send(3'd6, 8'h3C, k);
    send(3'd7, 8'hC3, k2);
    chk("t2_pend_accept", k2, k + 1);
    wait_cyc(k + 1);
    chk("t2_E6", E, 8'h40);
    chk("t2_ready_full1", wr_ready, 0);
    wait_cyc(k + 2);
    chk("t2_ready_full2", wr_ready, 0);
    wait_cyc(k + 4);
    chk("t2_E7", E, 8'h80);
    wait_idle();

    // Continuous stream
    for (int a = 1; a <= 4; a++) begin
      d = 8'($urandom);
      send(3'(a), d, k);
    end
    wait_idle();

    // Request arriving while in HOLD with empty slot
    send(3'd3, 8'h77, k);
    wait_cyc(k + 2);
    send(3'd5, 8'h99, k2);
    chk("t6_hold_accept", k2, k + 3);
    wait_cyc(k + 4);
    chk("t6_E5", E, 8'h20);
    wait_idle();

    // Asynchronous reset during a strobe with a pending request
    send(3'd2, 8'h11, k);
    send(3'd4, 8'h22, k2);
    wait_cyc(k + 1);
    chk("t4_E_before", E, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_E_async", E, 0);
    chk("t4_busy_async", busy, 0);
    sb.delete();
    last_pulse = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t4_busy_after", busy, 0);
    chk("t4_ready_after", wr_ready, 1);

    // Scan freeze during SETUP
    send(3'd5, 8'h5A, k);
    scan_en = 1'b1;
    sb[sb.size() - 1].cyc += 3;
    last_pulse += 3;
    for (int i = 0; i < 3; i++) begin
      wait_cyc(k + i);
      chk("t5_SE", SE, 1);
      chk("t5_E_frozen", E, 0);
      chk("t5_ready_frozen", wr_ready, 0);
    end
    @(posedge clk);
    #1;
    scan_en = 1'b0;
    wait_cyc(k + 3);
    chk("t5_E_release", E, 0);
    chk("t5_SE_off", SE, 0);
    wait_cyc(k + 4);
    chk("t5_E_after", E, 8'h20);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send(3'($urandom_range(0, 7)), 8'($urandom), k);
    end
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
